multihand_datapath: RTL and testbench

- Parametrised successor to the two-hand, three-card baccarat datapath.
- Holds NUM_HANDS hands of up to CARDS_PER_HAND cards each, fed by an internal rank source on a single clock.
- Dealing is a request/acknowledge transaction; per-hand running score (mod 10), card count, full and natural flags are kept in registers.
- Sits between the game controller FSM and the card7seg/display layer.

---
 rtl/multihand_pkg.sv | 18 +
 rtl/multihand_datapath_rank_source.sv | 29 ++
 rtl/multihand_datapath.sv | 121 ++++++++++++
 tb/tb_multihand_datapath.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/multihand_pkg.sv
// Shared types and helpers for the multi-hand baccarat datapath.
package multihand_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, SCORE} state_t;

  localparam int         RANK_W    = 4;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Face cards and tens count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] score, input logic [3:0] value);
    logic [4:0] s;
    s = {1'b0, score} + {1'b0, value};
    return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction
endpackage

// File: rtl/multihand_datapath_rank_source.sv
// Free-running rank source: 1..RANK_MAX counter, or an 8-bit LFSR when
// MULTIHAND_LFSR_EN is defined.
module rank_source
  import multihand_pkg::*;
#(
  parameter int RANK_MAX = 13
) (
  input  logic              clk,
  input  logic              reset,
  output logic [RANK_W-1:0] rank
);
`ifdef MULTIHAND_LFSR_EN
  logic [7:0] lfsr;

  // Fibonacci x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign rank = RANK_W'((32'(lfsr) % RANK_MAX) + 1);
`else
  always_ff @(posedge clk) begin
    if (reset)                            rank <= RANK_W'(1);
    else if (rank == RANK_W'(RANK_MAX))   rank <= RANK_W'(1);
    else                                  rank <= rank + RANK_W'(1);
  end
`endif
endmodule

// File: rtl/multihand_datapath.sv
// NUM_HANDS x CARDS_PER_HAND baccarat datapath with req/ack dealing.
// Rank source selectable via MULTIHAND_LFSR_EN (see rank_source).
module multihand_datapath
  import multihand_pkg::*;
#(
  parameter int  NUM_HANDS      = 2,
  parameter int  CARDS_PER_HAND = 3,
  parameter int  RANK_MAX       = 13,
  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CW = $clog2(CARDS_PER_HAND + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  deal_req,
  input  logic [HW-1:0]                         deal_hand,
  input  logic                                  clear_req,
  output logic                                  deal_ack,
  output logic                                  deal_err,
  output logic                                  busy,
  output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards,
  output logic [NUM_HANDS*4-1:0]                scores,
  output logic [NUM_HANDS*CW-1:0]               counts,
  output logic [NUM_HANDS-1:0]                  hand_full,
  output logic [NUM_HANDS-1:0]                  natural
);
  state_t state, state_n;
  logic [RANK_W-1:0] rank, rank_lat;
  logic [HW-1:0]     hand_lat;
  logic              req_ok, req_bad, sel_full;
  logic [3:0]        new_score;
  logic [3:0]        cur_score;

  logic [NUM_HANDS-1:0][CARDS_PER_HAND-1:0][3:0] card_r;
  logic [NUM_HANDS-1:0][3:0]                     score_r;
  logic [NUM_HANDS-1:0][CW-1:0]                  cnt_r;
  logic [NUM_HANDS-1:0]                          full_r, nat_r;

  rank_source #(.RANK_MAX(RANK_MAX)) u_rank (
    .clk  (clk),
    .reset(reset),
    .rank (rank)
  );

  always_comb begin
    state_n   = state;
    req_ok    = 1'b0;
    req_bad   = 1'b0;
    sel_full  = 1'b0;
    cur_score = 4'd0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (int'(deal_hand) == h && int'(cnt_r[h]) == CARDS_PER_HAND) sel_full = 1'b1;
      if (int'(hand_lat) == h) cur_score = score_r[h];
    end
    new_score = add_mod10(cur_score, card_value(rank_lat));
    case (state)
      IDLE: begin
        if (deal_req) begin
          if (int'(deal_hand) < NUM_HANDS && !sel_full) begin
            req_ok  = 1'b1;
            state_n = CAPTURE;
          end else begin
            req_bad = 1'b1;
          end
        end
      end
      CAPTURE: state_n = SCORE;
      SCORE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // clear wins over any request and aborts an in-flight deal
    if (clear_req) begin
      state_n = IDLE;
      req_ok  = 1'b0;
      req_bad = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_req) begin
      state    <= IDLE;
      deal_ack <= 1'b0;
      deal_err <= 1'b0;
      rank_lat <= '0;
      hand_lat <= '0;
      card_r   <= '0;
      score_r  <= '0;
      cnt_r    <= '0;
      full_r   <= '0;
      nat_r    <= '0;
    end else begin
      state    <= state_n;
      deal_ack <= (state == SCORE);
      deal_err <= req_bad;
      if (req_ok) begin
        rank_lat <= rank;
        hand_lat <= deal_hand;
      end
      for (int h = 0; h < NUM_HANDS; h++) begin
        if (int'(hand_lat) == h) begin
          if (state == CAPTURE) begin
            for (int s = 0; s < CARDS_PER_HAND; s++)
              if (int'(cnt_r[h]) == s) card_r[h][s] <= rank_lat;
            cnt_r[h] <= cnt_r[h] + CW'(1);
          end
          if (state == SCORE) begin
            score_r[h] <= new_score;
            full_r[h]  <= (int'(cnt_r[h]) == CARDS_PER_HAND);
            nat_r[h]   <= (int'(cnt_r[h]) == 2) && (new_score >= 4'd8);
          end
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign cards     = card_r;
  assign scores    = score_r;
  assign counts    = cnt_r;
  assign hand_full = full_r;
  assign natural   = nat_r;
endmodule

// File: tb/tb_multihand_datapath.sv
// Directed bench for multihand_datapath (3 hands so an out-of-range index exists).
module tb_multihand_datapath;
  localparam int NH = 3, CPH = 3, RM = 13, HW = 2, CW = 2;

  logic clk = 1'b0, reset = 1'b1, deal_req = 1'b0, clear_req = 1'b0;
  logic [HW-1:0] deal_hand = '0;
  logic deal_ack, deal_err, busy;
  logic [NH*CPH*4-1:0] cards;
  logic [NH*4-1:0] scores;
  logic [NH*CW-1:0] counts;
  logic [NH-1:0] hand_full, natural;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  multihand_datapath #(.NUM_HANDS(NH), .CARDS_PER_HAND(CPH), .RANK_MAX(RM)) dut (
    .clk(clk), .reset(reset), .deal_req(deal_req), .deal_hand(deal_hand),
    .clear_req(clear_req), .deal_ack(deal_ack), .deal_err(deal_err), .busy(busy),
    .cards(cards), .scores(scores), .counts(counts), .hand_full(hand_full),
    .natural(natural)
  );

  // reference rank source
`ifdef MULTIHAND_LFSR_EN
  logic [7:0] ml;
  always @(posedge clk)
    if (reset) ml <= 8'hA5;
    else       ml <= {ml[6:0], ml[7] ^ ml[5] ^ ml[4] ^ ml[3]};
  function automatic int model_rank();
    return (int'(ml) % RM) + 1;
  endfunction
`else
  int mr;
  always @(posedge clk)
    if (reset) mr <= 1;
    else       mr <= (mr == RM) ? 1 : mr + 1;
  function automatic int model_rank();
    return mr;
  endfunction
`endif

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int get_card(input int h, input int s);
    return int'(cards[(h*CPH+s)*4 +: 4]);
  endfunction
  function automatic int get_score(input int h);
    return int'(scores[h*4 +: 4]);
  endfunction
  function automatic int get_count(input int h);
    return int'(counts[h*CW +: CW]);
  endfunction

  task automatic wait_rank(input int want);
    bit hit = 0;
    for (int i = 0; i < 300; i++) begin
      if (model_rank() == want) begin hit = 1; break; end
      @(negedge clk);
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL wait_rank: got timeout want rank %0d", want);
    end
  endtask

  // Issue one request and record ack/err/busy at the three following negedges.
  task automatic deal3(input int h, input int want, input int ch, input int slot,
                       output logic [2:0] acks, output logic [2:0] errs,
                       output logic [2:0] busys, output int mid_card);
    wait_rank(want);
    deal_hand = HW'(h);
    deal_req  = 1'b1;
    mid_card  = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) deal_req = 1'b0;
      acks[i]  = deal_ack;
      errs[i]  = deal_err;
      busys[i] = busy;
      if (i == 1) mid_card = get_card(ch, slot);
    end
  endtask

  typedef struct {
    int hand; int rank; bit ok; int ch; int slot; int card;
    int score; int count; bit full; bit nat;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic [2:0] acks, errs, busys;
    int mid, nack, nerr;

    tbl[0] = '{0,  7, 1, 0, 0,  7, 7, 1, 0, 0};
    tbl[1] = '{0, 12, 1, 0, 1, 12, 7, 2, 0, 0};
    tbl[2] = '{1,  4, 1, 1, 0,  4, 4, 1, 0, 0};
    tbl[3] = '{1,  5, 1, 1, 1,  5, 9, 2, 0, 1};
    tbl[4] = '{1,  3, 1, 1, 2,  3, 2, 3, 1, 0};
    tbl[5] = '{1,  6, 0, 1, 2,  3, 2, 3, 1, 0};
    tbl[6] = '{3,  1, 0, 1, 0,  4, 2, 3, 1, 0};
    tbl[7] = '{2, 10, 1, 2, 0, 10, 0, 1, 0, 0};
    tbl[8] = '{2,  9, 1, 2, 1,  9, 9, 2, 0, 1};
    tbl[9] = '{0,  8, 1, 0, 2,  8, 5, 3, 1, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    // cycle 0
    chk("rst_cards", (cards == '0) ? 0 : 1, 0);
    chk("rst_scores", int'(scores), 0);
    chk("rst_counts", int'(counts), 0);
    chk("rst_flags", int'({hand_full, natural}), 0);
    chk("rst_ack_err_busy", int'({deal_ack, deal_err, busy}), 0);
`ifdef MULTIHAND_LFSR_EN
    chk("lfsr_first", int'(dut.u_rank.rank), 10);
    for (int i = 0; i < 300; i++) begin
      chk("lfsr_seq", int'(dut.u_rank.rank), model_rank());
      @(negedge clk);
    end
`else
    chk("rank_c0", int'(dut.u_rank.rank), 1);
    repeat (12) @(negedge clk);
    chk("rank_c12", int'(dut.u_rank.rank), 13);
    @(negedge clk);
    chk("rank_c13", int'(dut.u_rank.rank), 1);
`endif

    for (int v = 0; v < 10; v++) begin
      deal3(tbl[v].hand, tbl[v].rank, tbl[v].ch, tbl[v].slot, acks, errs, busys, mid);
      chk($sformatf("v%0d_ack", v), int'(acks), tbl[v].ok ? 4 : 0);
      chk($sformatf("v%0d_err", v), int'(errs), tbl[v].ok ? 0 : 1);
      chk($sformatf("v%0d_busy", v), int'(busys), tbl[v].ok ? 3 : 0);
      if (tbl[v].ok) chk($sformatf("v%0d_card_n2", v), mid, tbl[v].card);
      chk($sformatf("v%0d_card", v), get_card(tbl[v].ch, tbl[v].slot), tbl[v].card);
      chk($sformatf("v%0d_score", v), get_score(tbl[v].ch), tbl[v].score);
      chk($sformatf("v%0d_count", v), get_count(tbl[v].ch), tbl[v].count);
      chk($sformatf("v%0d_full", v), int'(hand_full[tbl[v].ch]), int'(tbl[v].full));
      chk($sformatf("v%0d_nat", v), int'(natural[tbl[v].ch]), int'(tbl[v].nat));
    end

    // deal_req held through busy: exactly one card, one ack
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("clr_counts", int'(counts), 0);
    wait_rank(2);
    deal_hand = 2'd0;
    deal_req  = 1'b1;
    nack = 0; nerr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) deal_req = 1'b0;
      nack += int'(deal_ack);
      nerr += int'(deal_err);
    end
    chk("busy_ign_acks", nack, 1);
    chk("busy_ign_errs", nerr, 0);
    chk("busy_ign_count", get_count(0), 1);
    chk("busy_ign_card", get_card(0, 0), 2);

    // clear during CAPTURE aborts the deal
    wait_rank(5);
    deal_hand = 2'd1;
    deal_req  = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    chk("abort_busy_pre", int'(busy), 1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("abort_cards", (cards == '0) ? 0 : 1, 0);
    chk("abort_scores", int'(scores), 0);
    chk("abort_counts", int'(counts), 0);
    chk("abort_flags", int'({hand_full, natural}), 0);
    chk("abort_busy", int'(busy), 0);
    nack = 0;
    repeat (3) begin @(negedge clk); nack += int'(deal_ack); end
    chk("abort_noack", nack, 0);
    chk("abort_counts_late", int'(counts), 0);

    // clear beats a simultaneous deal_req
    deal3(2, 9, 2, 0, acks, errs, busys, mid);
    chk("pre_clr_count2", get_count(2), 1);
    clear_req = 1'b1;
    deal_req  = 1'b1;
    deal_hand = 2'd0;
    @(negedge clk);
    clear_req = 1'b0;
    deal_req  = 1'b0;
    chk("prio_busy", int'(busy), 0);
    chk("prio_err", int'(deal_err), 0);
    chk("prio_counts", int'(counts), 0);
    nack = 0;
    repeat (3) begin @(negedge clk); nack += int'(deal_ack); end
    chk("prio_noack", nack, 0);
    chk("prio_counts_late", int'(counts), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
